// File: rtl/elastic_buffer.sv
// Elastic buffer: DEPTH-entry circular FIFO between a valid/ready producer and consumer,
// with an optional zero-latency bypass when empty and a synchronous flush.
//
// Handshake: a beat moves on an interface in a cycle where valid and ready are both 1 at
// the rising edge of clk. While valid_out=1 and ready_out=0, a stored beat keeps
// valid_out/data_out stable. ready_in is independent of ready_out, so a full buffer does
// not accept in the same cycle that it pops.
module elastic_buffer #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int PASSTHROUGH = 1,
   parameter int AF_LEVEL    = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [DATA_WIDTH-1:0]        data_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic                         almost_full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam bit PT = (PASSTHROUGH != 0);

   logic [DATA_WIDTH-1:0] storage [DEPTH];

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;

   logic accept;
   logic deliver;
   logic bypass;
   logic push;
   logic pop;

   always_comb begin
      full_o        = (count_q == DEPTH_C);
      empty_o       = (count_q == '0);
      almost_full_o = (count_q >= AF_C);
      count_o       = count_q;

      ready_in = !full_o && !flush_i && !rst;

      // In bypass mode an empty buffer presents the upstream beat directly.
      if (PT) begin
         valid_out = !flush_i && !rst && (!empty_o || valid_in);
         data_out  = empty_o ? data_in : storage[rd_ptr_q];
      end else begin
         valid_out = !flush_i && !rst && !empty_o;
         data_out  = storage[rd_ptr_q];
      end

      accept  = valid_in && ready_in;
      deliver = valid_out && ready_out;
      bypass  = PT && empty_o && accept && ready_out;
      push    = accept && !bypass;
      pop     = deliver && !empty_o;

      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

      if (flush_i) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Payload storage carries no reset; stale entries are unreachable once count is cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: a bypass instance and a registered instance share stimulus;
// a directed vector table, hand-written corner sequences and a queue-based reference model.
module tb_elastic_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          ready_out;

   logic          pt_ready_in, pt_valid_out, pt_full_o, pt_empty_o, pt_almost_full_o;
   logic [DW-1:0] pt_data_out;
   logic [2:0]    pt_count_o;
   logic          rg_ready_in, rg_valid_out, rg_full_o, rg_empty_o, rg_almost_full_o;
   logic [DW-1:0] rg_data_out;
   logic [2:0]    rg_count_o;

   elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PASSTHROUGH(1)) u_pt (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .valid_in(valid_in), .ready_in(pt_ready_in), .data_in(data_in),
      .valid_out(pt_valid_out), .ready_out(ready_out), .data_out(pt_data_out),
      .count_o(pt_count_o), .full_o(pt_full_o), .empty_o(pt_empty_o),
      .almost_full_o(pt_almost_full_o)
   );

   elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PASSTHROUGH(0)) u_rg (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .valid_in(valid_in), .ready_in(rg_ready_in), .data_in(data_in),
      .valid_out(rg_valid_out), .ready_out(ready_out), .data_out(rg_data_out),
      .count_o(rg_count_o), .full_o(rg_full_o), .empty_o(rg_empty_o),
      .almost_full_o(rg_almost_full_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // scoreboard: beats each instance currently holds, oldest first
   logic [DW-1:0] exp_q_pt[$];
   logic [DW-1:0] exp_q_rg[$];
   logic          ev_pt, er_pt, ev_rg, er_rg;

   typedef struct {
      logic          vin;
      logic [DW-1:0] din;
      logic          rout;
      logic          pt_vout;
      logic [DW-1:0] pt_dout;
      logic          pt_rdy;
      logic [2:0]    pt_cnt;
      logic          rg_vout;
      logic [DW-1:0] rg_dout;
      logic [2:0]    rg_cnt;
      logic [2:0]    pt_flags;   // {full, almost_full, empty}
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_one(input string tag, input bit pt, input int n, input logic [DW-1:0] head,
                            input logic a_v, input logic [DW-1:0] a_d, input logic a_r,
                            input logic [2:0] a_c, input logic a_f, input logic a_e,
                            input logic a_af, output logic e_v, output logic e_r);
      logic [DW-1:0] e_d;
      e_r = !rst && !flush_i && (n < DEPTH);
      e_v = !rst && !flush_i && ((n > 0) || (pt && valid_in));
      e_d = (n > 0) ? head : data_in;
      chk({tag, " ready_in"}, 32'(a_r), 32'(e_r));
      chk({tag, " valid_out"}, 32'(a_v), 32'(e_v));
      if (e_v) chk({tag, " data_out"}, 32'(a_d), 32'(e_d));
      chk({tag, " count_o"}, 32'(a_c), 32'(n));
      chk({tag, " full_o"}, 32'(a_f), 32'(n == DEPTH));
      chk({tag, " empty_o"}, 32'(a_e), 32'(n == 0));
      chk({tag, " almost_full_o"}, 32'(a_af), 32'(n >= DEPTH - 1));
   endtask

   task automatic model_check();
      check_one("pt", 1'b1, exp_q_pt.size(), (exp_q_pt.size() > 0) ? exp_q_pt[0] : 8'h00,
                pt_valid_out, pt_data_out, pt_ready_in, pt_count_o, pt_full_o, pt_empty_o,
                pt_almost_full_o, ev_pt, er_pt);
      check_one("rg", 1'b0, exp_q_rg.size(), (exp_q_rg.size() > 0) ? exp_q_rg[0] : 8'h00,
                rg_valid_out, rg_data_out, rg_ready_in, rg_count_o, rg_full_o, rg_empty_o,
                rg_almost_full_o, ev_rg, er_rg);
   endtask

   // Applies one edge to the model using the values expected just before it.
   task automatic model_update();
      int n;
      n = exp_q_pt.size();
      if (rst || flush_i) exp_q_pt.delete();
      else begin
         if (ev_pt && ready_out && n > 0) void'(exp_q_pt.pop_front());
         if (valid_in && er_pt && !(n == 0 && ready_out)) exp_q_pt.push_back(data_in);
      end
      n = exp_q_rg.size();
      if (rst || flush_i) exp_q_rg.delete();
      else begin
         if (ev_rg && ready_out && n > 0) void'(exp_q_rg.pop_front());
         if (valid_in && er_rg) exp_q_rg.push_back(data_in);
      end
   endtask

   // driver tasks
   task automatic drive(input logic f, input logic v, input logic [DW-1:0] d, input logic r);
      flush_i   = f;
      valid_in  = v;
      data_in   = d;
      ready_out = r;
   endtask

   task automatic cycle();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic chk_both_idle(input string tag);
      chk({tag, " pt valid_out"}, 32'(pt_valid_out), 32'(0));
      chk({tag, " rg valid_out"}, 32'(rg_valid_out), 32'(0));
      chk({tag, " pt count_o"}, 32'(pt_count_o), 32'(0));
      chk({tag, " rg count_o"}, 32'(rg_count_o), 32'(0));
   endtask

   initial begin
      //           vin  din    rout | pt: vout dout  rdy  cnt  | rg: vout dout cnt | flags
      vecs[0]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 3'b001};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h5A, 3'd1, 3'b001};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 3'b001};
      vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 3'b001};
      vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b1, 3'd1, 1'b1, 8'h01, 3'd1, 3'b000};
      vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b1, 3'd2, 1'b1, 8'h01, 3'd2, 3'b000};
      vecs[6]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 1'b1, 3'd3, 1'b1, 8'h01, 3'd3, 3'b010};
      vecs[7]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 8'h01, 1'b0, 3'd4, 1'b1, 8'h01, 3'd4, 3'b110};
      vecs[8]  = '{1'b1, 8'hBB, 1'b1, 1'b1, 8'h01, 1'b0, 3'd4, 1'b1, 8'h01, 3'd4, 3'b110};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 3'd3, 1'b1, 8'h02, 3'd3, 3'b010};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 3'd2, 1'b1, 8'h03, 3'd2, 3'b000};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 3'd1, 1'b1, 8'h04, 3'd1, 3'b000};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 3'b001};

      rst = 1'b1;
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // directed vector table: bypass, registered latency, fill to full, drain
      for (int i = 0; i < 13; i++) begin
         drive(1'b0, vecs[i].vin, vecs[i].din, vecs[i].rout);
         #1;
         chk($sformatf("vec%0d pt valid_out", i), 32'(pt_valid_out), 32'(vecs[i].pt_vout));
         if (vecs[i].pt_vout)
            chk($sformatf("vec%0d pt data_out", i), 32'(pt_data_out), 32'(vecs[i].pt_dout));
         chk($sformatf("vec%0d pt ready_in", i), 32'(pt_ready_in), 32'(vecs[i].pt_rdy));
         chk($sformatf("vec%0d pt count_o", i), 32'(pt_count_o), 32'(vecs[i].pt_cnt));
         chk($sformatf("vec%0d pt flags", i), 32'({pt_full_o, pt_almost_full_o, pt_empty_o}),
             32'(vecs[i].pt_flags));
         chk($sformatf("vec%0d rg valid_out", i), 32'(rg_valid_out), 32'(vecs[i].rg_vout));
         if (vecs[i].rg_vout)
            chk($sformatf("vec%0d rg data_out", i), 32'(rg_data_out), 32'(vecs[i].rg_dout));
         chk($sformatf("vec%0d rg ready_in", i), 32'(rg_ready_in), 32'(vecs[i].pt_rdy));
         chk($sformatf("vec%0d rg count_o", i), 32'(rg_count_o), 32'(vecs[i].rg_cnt));
         cycle();
      end

      // steady push+pop at count 2 across pointer wrap
      drive(1'b0, 1'b1, 8'h10, 1'b0); cycle();
      drive(1'b0, 1'b1, 8'h11, 1'b0); cycle();
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 8'(8'h20 + k), 1'b1);
         cycle();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("steady pt count_o", 32'(pt_count_o), 32'(2));
      chk("steady rg count_o", 32'(rg_count_o), 32'(2));
      chk("steady pt head", 32'(pt_data_out), 32'(8'h28));
      cycle();

      // flush at count 3 with a competing upstream beat
      drive(1'b0, 1'b1, 8'h30, 1'b0); cycle();
      drive(1'b1, 1'b1, 8'hFF, 1'b1);
      #1;
      chk("flush pt valid_out", 32'(pt_valid_out), 32'(0));
      chk("flush pt ready_in", 32'(pt_ready_in), 32'(0));
      chk("flush rg valid_out", 32'(rg_valid_out), 32'(0));
      chk("flush rg ready_in", 32'(rg_ready_in), 32'(0));
      cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      chk_both_idle("post-flush");
      chk("post-flush pt empty_o", 32'(pt_empty_o), 32'(1));
      cycle();

      // reset pulsed between edges while holding two beats
      drive(1'b0, 1'b1, 8'h41, 1'b0); cycle();
      drive(1'b0, 1'b1, 8'h42, 1'b0); cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      rst = 1'b1;
      #1;
      chk_both_idle("rst-pulse");
      chk("rst-pulse pt ready_in", 32'(pt_ready_in), 32'(0));
      chk("rst-pulse rg ready_in", 32'(rg_ready_in), 32'(0));
      #1;
      rst = 1'b0;
      exp_q_pt.delete();
      exp_q_rg.delete();
      #1;
      chk_both_idle("after-rst");
      cycle();
      cycle();

      // randomized traffic against the queue model
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            rst = 1'b1;
            exp_q_pt.delete();
            exp_q_rg.delete();
         end else begin
            rst = 1'b0;
         end
         drive(1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 70), 8'($urandom),
               1'($urandom_range(0, 99) < ((i % 300) < 150 ? 30 : 85)));
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/elastic_buffer.md
ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, storage entries (power of two, >=2).
REQ-003 The block SHALL have parameter PASSTHROUGH, default 1: 1 = zero-latency bypass when empty; 0 = fully registered output path.
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-005 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port flush_i  input  1  discard all buffered beats.
REQ-008 The block SHALL have port valid_in  input  1  upstream beat valid.
REQ-009 The block SHALL have port ready_in  output  1  block can accept a beat.
REQ-010 The block SHALL have port data_in  input  DATA_WIDTH  upstream payload.
REQ-011 The block SHALL have port valid_out  output  1  downstream beat valid.
REQ-012 The block SHALL have port ready_out  input  1  downstream can accept.
REQ-013 The block SHALL have port data_out  output  DATA_WIDTH  downstream payload.
REQ-014 The block SHALL have port count_o  output  $clog2(DEPTH+1)  stored-entry count.
REQ-015 The block SHALL have ports full_o, empty_o, almost_full_o  output  1 each  status flags.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular FIFO with rd/wr pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 ready_in SHALL equal !full_o && !flush_i && !rst; no combinational path from ready_out to ready_in.
REQ-018 Accept = valid_in && ready_in; deliver = valid_out && ready_out.
REQ-019 PASSTHROUGH=1: valid_out = !empty_o || valid_in; data_out = empty_o ? data_in : head entry.
REQ-020 PASSTHROUGH=1: beat accepted while empty with ready_out=1 SHALL bypass storage (no write, count unchanged), latency 0 cycles.
REQ-021 PASSTHROUGH=0: valid_out = !empty_o; data_out = head entry; every accepted beat written to storage, latency 1 cycle minimum.
REQ-022 push = accept && !bypass; pop = deliver && !empty_o; count_o next = count_o + push - pop.
REQ-023 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-024 full_o = (count_o == DEPTH); empty_o = (count_o == 0); almost_full_o = (count_o >= AF_LEVEL); all derived from registered count.
REQ-025 When full, a pop in the same cycle SHALL NOT enable acceptance in that cycle; ready_in rises the following cycle.
REQ-026 Beats SHALL be delivered in strict acceptance order, no loss or duplication except by flush.
REQ-027 flush_i=1: valid_out forced 0, ready_in forced 0, no accept/deliver; at next edge count_o=0, pointers=0.
REQ-028 flush_i SHALL take priority over any concurrent valid_in/ready_out activity.
REQ-029 data_out SHALL be don't-care while valid_out=0; data_out/valid_out SHALL stay stable while valid_out=1 && ready_out=0 (stored beats).

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) clear count_o, pointers; ready_in=0, valid_out=0, empty_o=1, full_o=0, almost_full_o=0 (AF_LEVEL>=1).
REQ-031 Storage array contents SHALL NOT be reset.
REQ-032 Reset deassertion SHALL be sampled on clk; first accept possible on first edge after rst=0.
REQ-033 Reset asserted mid-transfer SHALL discard all stored beats; no beat delivered after reset deasserts until newly accepted.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-034 PASSTHROUGH=1, empty, ready_out=1, valid_in=1 data_in=0x5A -> same cycle valid_out=1 data_out=0x5A, count_o stays 0.
REQ-035 ready_out=0, push 0x01..0x04 -> count_o=4, full_o=1, ready_in=0, almost_full_o=1 from count 3; then ready_out=1 -> out 0x01,0x02,0x03,0x04 in consecutive cycles.
REQ-036 count_o=2, valid_in=1 and ready_out=1 for 10 cycles -> count_o stays 2, order preserved across pointer wrap.
REQ-037 count_o=3, flush_i=1 with valid_in=1 data_in=0xFF -> valid_out=0, ready_in=0; next cycle count_o=0, empty_o=1, 0xFF never delivered.
REQ-038 PASSTHROUGH=0, empty, accept 0x33 at edge N -> valid_out=1 data_out=0x33 after edge N, not before.
REQ-039 count_o=2, rst pulsed between edges -> count_o=0, valid_out=0, ready_in=0 immediately; stale beats never reappear.
